// File: rtl/rvfi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_pkg
// Description : RVFI commit record type and replay-driver shared definitions.
// Revision    : 1.0 - initial release
// ============================================================================
package rvfi_pkg;

    localparam logic [31:0] RVFI_STOP_INSN = 32'h00000073;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_instr_t;

    typedef enum logic [1:0] {
        REPLAY_IDLE,
        REPLAY_RUN,
        REPLAY_DONE
    } replay_state_e;

    typedef struct packed {
        rvfi_instr_t rec;
        logic        last;
    } replay_entry_t;

    // Trap records (valid=0) never stop the replay through their insn field.
    function automatic logic is_stop_entry(input replay_entry_t e);
        return (e.rec.valid && (e.rec.insn == RVFI_STOP_INSN)) || e.last;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvfi_replay_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_replay_fifo
// Description : Single-push, multi-pop record FIFO exposing its head entries.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_replay_fifo
    import rvfi_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPOP  = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int NW   = $clog2(NPOP + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push_i,
    input  replay_entry_t             push_data_i,
    input  logic [NW-1:0]             pop_n_i,
    output logic [CW-1:0]             count_o,
    output replay_entry_t [NPOP-1:0]  head_o
);

    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    replay_entry_t mem_q [DEPTH];

    // Pointers are exactly log2(DEPTH) bits so advancing them wraps for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_n_i);
        count_d  = count_q + CW'(push_i) - CW'(pop_n_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar gi = 0; gi < NPOP; gi++) begin : g_head
        assign head_o[gi] = mem_q[rd_ptr_q + PW'(gi)];
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/rvfi_replay_driver.sv
`default_nettype none
// ============================================================================
// Module      : rvfi_replay_driver
// Description : Replays buffered RVFI records onto a multi-port commit bus.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfi_replay_driver
    import rvfi_pkg::*;
#(
    parameter int          NR_COMMIT_PORTS = 2,
    parameter int          FIFO_DEPTH      = 8,
    parameter int unsigned TIMEOUT         = 20000000,
    localparam int         IW              = $clog2(NR_COMMIT_PORTS + 1),
    localparam int         CW              = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic                                rec_valid_i,
    output logic                                rec_ready_o,
    input  rvfi_instr_t                         rec_i,
    input  logic                                rec_last_i,
    input  logic [IW-1:0]                       max_issue_i,
    output rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_o,
    output logic                                done_o,
    output logic                                timeout_o,
    output logic [31:0]                         issued_cnt_o
);

    replay_state_e                      state_q;
    replay_state_e                      state_d;
    rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_q;
    rvfi_instr_t [NR_COMMIT_PORTS-1:0]  rvfi_d;
    logic                               timeout_q;
    logic                               timeout_d;
    logic [31:0]                        issued_q;
    logic [31:0]                        issued_d;
    logic [31:0]                        tmo_q;
    logic [31:0]                        tmo_d;

    logic [CW-1:0]                        w_count;
    replay_entry_t [NR_COMMIT_PORTS-1:0]  w_head;
    replay_entry_t                        w_push_data;
    logic                                 w_push;
    logic [IW-1:0]                        w_pop_n;
    logic                                 w_stop_hit;
    logic                                 w_tmo_hit;
    logic [32:0]                          w_issued_sum;

    assign rec_ready_o = !rst_i && (state_q != REPLAY_DONE) && (w_count < CW'(FIFO_DEPTH));
    assign w_push      = rec_valid_i && rec_ready_o;
    assign w_push_data = '{rec: rec_i, last: rec_last_i};

    rvfi_replay_fifo #(
        .DEPTH (FIFO_DEPTH),
        .NPOP  (NR_COMMIT_PORTS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_n_i     (w_pop_n),
        .count_o     (w_count),
        .head_o      (w_head)
    );

    always_comb begin
        state_d    = state_q;
        rvfi_d     = '0;
        timeout_d  = timeout_q;
        tmo_d      = tmo_q;
        w_pop_n    = '0;
        w_stop_hit = 1'b0;
        w_tmo_hit  = 1'b0;

        case (state_q)
            REPLAY_IDLE: begin
                if (start_i) begin
                    state_d = REPLAY_RUN;
                    tmo_d   = '0;
                end
            end
            REPLAY_RUN: begin
                tmo_d     = tmo_q + 32'd1;
                w_tmo_hit = (tmo_q == 32'(TIMEOUT - 1));
                // Ports fill in FIFO order; a stop or last record closes the beat.
                for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
                    if (!w_stop_hit && (IW'(p) < max_issue_i) && (CW'(p) < w_count)) begin
                        rvfi_d[p]  = w_head[p].rec;
                        w_pop_n    = w_pop_n + IW'(1);
                        w_stop_hit = is_stop_entry(w_head[p]);
                    end
                end
                if (w_stop_hit) begin
                    state_d = REPLAY_DONE;
                end else if (w_tmo_hit) begin
                    rvfi_d    = '0;
                    w_pop_n   = '0;
                    state_d   = REPLAY_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign w_issued_sum = {1'b0, issued_q} + 33'(w_pop_n);
    assign issued_d     = w_issued_sum[32] ? 32'hFFFF_FFFF : w_issued_sum[31:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= REPLAY_IDLE;
            rvfi_q    <= '0;
            timeout_q <= 1'b0;
            issued_q  <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rvfi_q    <= rvfi_d;
            timeout_q <= timeout_d;
            issued_q  <= issued_d;
            tmo_q     <= tmo_d;
        end
    end

    assign rvfi_o       = rvfi_q;
    assign done_o       = (state_q == REPLAY_DONE);
    assign timeout_o    = timeout_q;
    assign issued_cnt_o = issued_q;

endmodule
`default_nettype wire

// File: tb/tb_rvfi_replay_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfi_replay_driver
// Description : Self-checking bench for rvfi_replay_driver (vectors + model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfi_replay_driver;
    import rvfi_pkg::*;

    localparam int NR       = 2;
    localparam int DEPTH    = 8;
    localparam int TO_MAIN  = 200;
    localparam int TO_SHORT = 16;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] STOP = 32'h00000073;

    logic clk = 1'b0;
    logic rst, start, vld, last;
    rvfi_instr_t rec;
    logic [1:0] mi;

    logic ready, done, tout;
    rvfi_instr_t [NR-1:0] rv;
    logic [31:0] cnt;
    logic ready_t, done_t, tout_t;
    rvfi_instr_t [NR-1:0] rv_t;
    logic [31:0] cnt_t;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rvfi_replay_driver #(.NR_COMMIT_PORTS(NR), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO_MAIN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rec_valid_i(vld), .rec_ready_o(ready),
        .rec_i(rec), .rec_last_i(last), .max_issue_i(mi), .rvfi_o(rv), .done_o(done),
        .timeout_o(tout), .issued_cnt_o(cnt)
    );

    rvfi_replay_driver #(.NR_COMMIT_PORTS(NR), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO_SHORT)) dut_t (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rec_valid_i(vld), .rec_ready_o(ready_t),
        .rec_i(rec), .rec_last_i(last), .max_issue_i(mi), .rvfi_o(rv_t), .done_o(done_t),
        .timeout_o(tout_t), .issued_cnt_o(cnt_t)
    );

    function automatic rvfi_instr_t mk(input logic [31:0] pc, input logic [31:0] insn, input logic v);
        rvfi_instr_t r = '0;
        r.valid    = v;
        r.trap     = !v;
        r.order    = {32'h0, pc};
        r.insn     = insn;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        r.rd_addr  = pc[6:2];
        r.rd_wdata = ~pc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_bus(input string nm, input rvfi_instr_t [NR-1:0] act, input rvfi_instr_t [NR-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got p0(v=%b pc=%h insn=%h) p1(v=%b pc=%h insn=%h) expected p0(v=%b pc=%h insn=%h) p1(v=%b pc=%h insn=%h)",
                     nm, act[0].valid, act[0].pc_rdata, act[0].insn, act[1].valid, act[1].pc_rdata, act[1].insn,
                     exp[0].valid, exp[0].pc_rdata, exp[0].insn, exp[1].valid, exp[1].pc_rdata, exp[1].insn);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; start = 0; vld = 0; last = 0; mi = 0; rec = '0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic push(input rvfi_instr_t r);
        vld = 1; rec = r; last = 0;
        tick();
        vld = 0;
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct { rvfi_instr_t rec; bit last; } ment_t;
    ment_t mq[$];
    int    m_st;            // 0 idle, 1 run, 2 done
    rvfi_instr_t [NR-1:0] m_rv;
    bit    m_tout;
    bit    m_acc;
    longint m_cnt;
    int    m_tmo;

    task automatic model_step();
        int n;
        int take;
        bit stop;
        m_acc = 0;
        if (rst) begin
            mq.delete(); m_st = 0; m_rv = '0; m_tout = 0; m_cnt = 0; m_tmo = 0;
            return;
        end
        m_acc = vld && (m_st != 2) && (mq.size() < DEPTH);
        m_rv  = '0;
        if (m_st == 0) begin
            if (start) begin m_st = 1; m_tmo = 0; end
        end else if (m_st == 1) begin
            n = int'(mi);
            if (mq.size() < n) n = mq.size();
            if (NR < n) n = NR;
            take = 0; stop = 0;
            for (int k = 0; k < n && !stop; k++) begin
                m_rv[k] = mq[k].rec;
                take++;
                if ((mq[k].rec.valid && mq[k].rec.insn == STOP) || mq[k].last) stop = 1;
            end
            m_tmo++;
            if (stop) m_st = 2;
            else if (m_tmo == TO_MAIN) begin m_rv = '0; take = 0; m_st = 2; m_tout = 1; end
            for (int k = 0; k < take; k++) void'(mq.pop_front());
            m_cnt += take;
            if (m_cnt > 64'hFFFF_FFFF) m_cnt = 64'hFFFF_FFFF;
        end
        if (m_acc) mq.push_back('{rec: rec, last: last});
    endtask

    task automatic cyc();
        model_step();
        tick();
        chk("m_ready", ready, (!rst && m_st != 2 && mq.size() < DEPTH));
        chk("m_done", done, (m_st == 2));
        chk("m_timeout", tout, m_tout);
        chk("m_issued", cnt, m_cnt[31:0]);
        chk_bus("m_rvfi", rv, m_rv);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          start;
        bit          vld;
        logic [31:0] pc;
        logic [1:0]  mi;
        bit          e_ready;
        bit          e_done;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic [31:0] e_cnt;
    } vec_t;
    vec_t tv[8];

    rvfi_instr_t [NR-1:0] ex;
    ment_t obs[$];
    logic [31:0] obs_pc[$];

    initial begin
        tv[0] = '{0, 1, 32'h80000000, 2'd2, 1, 0, 32'h0, 32'h0, 32'd0};
        tv[1] = '{0, 1, 32'h80000004, 2'd2, 1, 0, 32'h0, 32'h0, 32'd0};
        tv[2] = '{0, 1, 32'h80000008, 2'd2, 1, 0, 32'h0, 32'h0, 32'd0};
        tv[3] = '{0, 1, 32'h8000000C, 2'd2, 1, 0, 32'h0, 32'h0, 32'd0};
        tv[4] = '{1, 0, 32'h0,        2'd2, 1, 0, 32'h0, 32'h0, 32'd0};
        tv[5] = '{0, 0, 32'h0,        2'd2, 1, 0, 32'h80000000, 32'h80000004, 32'd2};
        tv[6] = '{0, 0, 32'h0,        2'd2, 1, 0, 32'h80000008, 32'h8000000C, 32'd4};
        tv[7] = '{0, 0, 32'h0,        2'd2, 1, 0, 32'h0, 32'h0, 32'd4};

        // Reset state while rst is held.
        rst = 1; start = 0; vld = 1; last = 0; mi = 2; rec = mk(32'h1234, NOP, 1);
        tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", tout, 0);
        chk("rst_issued", cnt, 0);
        chk_bus("rst_rvfi", rv, '0);
        rst = 0; vld = 0;

        // Preload 4, start, two full beats.
        for (int i = 0; i < 8; i++) begin
            start = tv[i].start; vld = tv[i].vld; mi = tv[i].mi; last = 0;
            rec = mk(tv[i].pc, NOP, 1);
            tick();
            ex[0] = (tv[i].e_pc0 == 0) ? '0 : mk(tv[i].e_pc0, NOP, 1);
            ex[1] = (tv[i].e_pc1 == 0) ? '0 : mk(tv[i].e_pc1, NOP, 1);
            chk("vec_ready", ready, tv[i].e_ready);
            chk("vec_done", done, tv[i].e_done);
            chk("vec_issued", cnt, tv[i].e_cnt);
            chk_bus("vec_rvfi", rv, ex);
        end
        start = 0;
        chk("vec_count_empty", dut.w_count, 0);

        // Stall with max_issue 0: nothing moves, timeout counter runs.
        do_reset();
        for (int i = 0; i < 3; i++) push(mk(32'h80001000 + 32'(4 * i), NOP, 1));
        start = 1; mi = 0;
        tick();
        start = 0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_bus("stall_rvfi", rv, '0);
            chk("stall_count", dut.w_count, 3);
            chk("stall_tmo", dut.tmo_q, k);
        end
        chk("stall_done", done, 0);

        // Stop instruction on port 0 of the second beat.
        do_reset();
        push(mk(32'h80002000, NOP, 1));
        push(mk(32'h80002004, NOP, 1));
        push(mk(32'h80002008, STOP, 1));
        push(mk(32'h8000200C, NOP, 1));
        start = 1; mi = 0;
        tick();
        start = 0; mi = 2;
        tick();
        ex[0] = mk(32'h80002000, NOP, 1); ex[1] = mk(32'h80002004, NOP, 1);
        chk_bus("stop_beat1", rv, ex);
        tick();
        ex[0] = mk(32'h80002008, STOP, 1); ex[1] = '0;
        chk_bus("stop_beat2", rv, ex);
        chk("stop_done", done, 1);
        chk("stop_ready", ready, 0);
        chk("stop_issued", cnt, 3);
        chk("stop_count", dut.w_count, 1);
        tick();
        chk_bus("stop_after", rv, '0);
        chk("stop_hold", done, 1);

        // Reset mid-run with 5 records buffered.
        do_reset();
        for (int i = 0; i < 6; i++) push(mk(32'h80003000 + 32'(4 * i), NOP, 1));
        start = 1; mi = 0;
        tick();
        start = 0; mi = 1;
        tick();
        ex[0] = mk(32'h80003000, NOP, 1); ex[1] = '0;
        chk_bus("mid_beat", rv, ex);
        chk("mid_count", dut.w_count, 5);
        rst = 1; mi = 0;
        #1;
        chk("mid_rst_ready", ready, 0);
        tick();
        chk_bus("mid_rvfi", rv, '0);
        chk("mid_state", dut.state_q, REPLAY_IDLE);
        chk("mid_count0", dut.w_count, 0);
        chk("mid_issued", cnt, 0);
        chk("mid_done", done, 0);
        rst = 0;

        // Timeout with an empty FIFO on the short-timeout instance.
        do_reset();
        start = 1;
        tick();
        start = 0;
        for (int k = 1; k <= TO_SHORT; k++) begin
            tick();
            if (k == TO_SHORT - 1) chk("tmo_early_done", done_t, 0);
            if (k == TO_SHORT) begin
                chk("tmo_done", done_t, 1);
                chk("tmo_flag", tout_t, 1);
                chk_bus("tmo_rvfi", rv_t, '0);
            end
        end

        // Stop and timeout in the same cycle: stop wins.
        do_reset();
        push(mk(32'h80004000, STOP, 1));
        start = 1; mi = 0;
        tick();
        start = 0;
        for (int k = 1; k < TO_SHORT; k++) tick();
        mi = 1;
        tick();
        ex[0] = mk(32'h80004000, STOP, 1); ex[1] = '0;
        chk("both_done", done_t, 1);
        chk("both_timeout", tout_t, 0);
        chk_bus("both_rvfi", rv_t, ex);
        mi = 0;

        // Fill to depth, pop on a full FIFO, then 20 records through the wrap.
        rst = 1; start = 0; vld = 0; mi = 2; last = 0;
        cyc();
        rst = 0;
        begin
            int idx;
            idx = 0;
            obs_pc.delete();
            for (int i = 0; i < DEPTH; i++) begin
                vld = 1; rec = mk(32'h90000000 + 32'(4 * idx), NOP, 1); last = 0;
                cyc();
                if (m_acc) idx++;
            end
            chk("full_ready", ready, 0);
            start = 1; vld = 1; rec = mk(32'h90000000 + 32'(4 * idx), NOP, 1);
            cyc();
            start = 0;
            cyc();
            chk("pop_full_ready", ready, 1);
            chk("pop_full_count", dut.w_count, DEPTH - 2);
            for (int p = 0; p < NR; p++) if (rv[p].valid) obs_pc.push_back(rv[p].pc_rdata);
            for (int c = 0; c < 100 && !done; c++) begin
                vld  = (idx < 20);
                last = (idx == 19);
                rec  = mk(32'h90000000 + 32'(4 * idx), NOP, 1);
                cyc();
                if (m_acc) idx++;
                for (int p = 0; p < NR; p++) if (rv[p].valid) obs_pc.push_back(rv[p].pc_rdata);
            end
            vld = 0; last = 0;
            chk("wrap_done", done, 1);
            chk("wrap_total", obs_pc.size(), 20);
            for (int i = 0; i < obs_pc.size() && i < 20; i++)
                chk("wrap_order", obs_pc[i], 32'h90000000 + 32'(4 * i));
        end

        // Randomised run against the reference model.
        rst = 1; start = 0; vld = 0; mi = 0; last = 0;
        cyc();
        for (int c = 0; c < 800; c++) begin
            rst   = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 3) == 0);
            vld   = $urandom_range(0, 1);
            mi    = 2'($urandom_range(0, 2));
            last  = ($urandom_range(0, 39) == 0);
            rec   = mk($urandom, ($urandom_range(0, 29) == 0) ? STOP : $urandom,
                       ($urandom_range(0, 7) != 0));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
